// File: rtl/wisc_pkg.sv
// ----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC 16-bit core flow-control logic:
//   - opcode constants (instr[15:12])
//   - branch condition codes (instr[11:9])
//   - flag register bit indices ({Z,N,V})
//   - halt state machine enum
//   - helper that tells which flag bits an opcode updates
// ----------------------------------------------------------------------------
package wisc_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // Branch condition codes
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    // Flag register layout is {Z,N,V}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // Halt state machine
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Mask of flag bits an opcode writes. Arithmetic writes all three,
    // logical/shift ops write Z only, everything else leaves the flags alone.
    function automatic logic [2:0] flag_write_mask(input logic [3:0] op);
        logic [2:0] mask;
        mask = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                  mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR:  mask[FLAG_Z] = 1'b1;
            default:                         mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Combinational evaluation of a branch condition code against the flag
// register.
//   ccc       in  3  condition code from instr[11:9]
//   flags     in  3  registered {Z,N,V}
//   cond_true out 1  condition satisfied
// ----------------------------------------------------------------------------
import wisc_pkg::*;

module branch_cond_eval (
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic z;
    logic n;
    logic v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    // Decode the condition code; GE is Z | (!Z & !N), which reduces to Z | !N.
    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            CC_NE:   cond_true = ~z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = ~z & ~n;
            CC_LT:   cond_true = n;
            CC_GE:   cond_true = z | ~n;
            CC_LE:   cond_true = n | z;
            CC_OV:   cond_true = v;
            CC_UNC:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flow_ctrl.sv
// ----------------------------------------------------------------------------
// pc_flow_ctrl
// Program counter, {Z,N,V} flag register and halt state machine of the
// single-cycle WISC core. Resolves B/BR, produces the next PC and the PCS
// writeback value, and freezes fetch after HLT until reset.
//   clk          in   1   core clock
//   rst_n        in   1   synchronous active-low reset
//   stall        in   1   hold PC, flags and FSM this cycle
//   instr        in   16  [15:12] opcode, [11:9] ccc, [8:0] imm9
//   branch       in   1   decoder Branch strobe (B or BR)
//   branch_reg   in   1   decoder BranchReg strobe (BR)
//   pcs          in   1   decoder PCS strobe
//   halt_in      in   1   decoder Halt strobe
//   rs_data      in   16  BR target from register file
//   alu_z/n/v    in   1   ALU flag results for current instruction
//   pc           out  16  current fetch address
//   pc_plus2     out  16  pc+2, PCS writeback data
//   branch_taken out  1   current branch resolved taken
//   flags        out  3   {Z,N,V}
//   halted       out  1   core stopped
// ----------------------------------------------------------------------------
import wisc_pkg::*;

module pc_flow_ctrl #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [15:0] instr,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic        pcs,
    input  logic        halt_in,
    input  logic [15:0] rs_data,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        branch_taken,
    output logic [2:0]  flags,
    output logic        halted
);

    state_t      state;
    logic        cond_true;
    logic [15:0] br_offset;
    logic [15:0] next_pc;
    logic [2:0]  wr_mask;
    logic [2:0]  next_flags;
    logic        unused_pcs;

    // pcs only selects writeback data elsewhere; pc_plus2 is always valid.
    assign unused_pcs = pcs;

    branch_cond_eval u_cond (
        .ccc       (instr[11:9]),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign pc_plus2     = pc + 16'd2;
    assign branch_taken = branch & ~halted & cond_true;

    // imm9 is a signed word offset: sign-extend and shift left by one.
    assign br_offset = {{6{instr[8]}}, instr[8:0], 1'b0};

    // Next-PC mux: BR jumps to rs_data untouched, B is PC-relative.
    always_comb begin
        next_pc = pc_plus2;
        if (branch_taken) begin
            if (branch_reg) begin
                next_pc = rs_data;
            end else begin
                next_pc = pc_plus2 + br_offset;
            end
        end
    end

    // Only the flag bits the opcode owns are replaced; the rest hold.
    assign wr_mask    = flag_write_mask(instr[15:12]);
    assign next_flags = (flags & ~wr_mask) | ({alu_z, alu_n, alu_v} & wr_mask);

    // PC, flags and halt FSM. Once HALTED nothing but reset moves the core;
    // on HLT the PC stays on the HLT address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= PC_RESET;
            flags  <= 3'b000;
            state  <= RUN;
            halted <= 1'b0;
        end else if (state == RUN && !stall) begin
            flags <= next_flags;
            if (halt_in) begin
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_flow_ctrl
// Table-driven bench for pc_flow_ctrl. Each vector is one clock cycle: the
// combinational outputs are checked before the edge, and the registered
// results expected after the edge go through a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_pc_flow_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [15:0] instr;
    logic        branch;
    logic        branch_reg;
    logic        pcs;
    logic        halt_in;
    logic [15:0] rs_data;
    logic        alu_z;
    logic        alu_n;
    logic        alu_v;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        branch_taken;
    logic [2:0]  flags;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [15:0] instr;
        logic        branch;
        logic        branch_reg;
        logic        pcs;
        logic        halt_in;
        logic [15:0] rs_data;
        logic        z;
        logic        n;
        logic        v;
        logic        chk_comb;
        logic        exp_bt;
        logic [15:0] exp_pp2;
        logic [15:0] exp_pc;
        logic [2:0]  exp_flags;
        logic        exp_halted;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  flags;
        logic        halted;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pc_flow_ctrl #(.PC_RESET(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .instr        (instr),
        .branch       (branch),
        .branch_reg   (branch_reg),
        .pcs          (pcs),
        .halt_in      (halt_in),
        .rs_data      (rs_data),
        .alu_z        (alu_z),
        .alu_n        (alu_n),
        .alu_v        (alu_v),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .branch_taken (branch_taken),
        .flags        (flags),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] ccc,
                                       input logic [8:0] imm);
        return {op, ccc, imm};
    endfunction

    task automatic compare(input string name, input int idx,
                           input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic st, input logic [3:0] op,
                        input logic [2:0] ccc, input logic [8:0] imm,
                        input logic br, input logic brr, input logic p, input logic h,
                        input logic [15:0] rs, input logic z, input logic n, input logic v,
                        input logic chk, input logic bt, input logic [15:0] pp2,
                        input logic [15:0] epc, input logic [2:0] efl, input logic eh);
        vec_t t;
        t.rst_n = r;      t.stall = st;       t.instr = mk(op, ccc, imm);
        t.branch = br;    t.branch_reg = brr; t.pcs = p;  t.halt_in = h;
        t.rs_data = rs;   t.z = z;  t.n = n;  t.v = v;
        t.chk_comb = chk; t.exp_bt = bt;      t.exp_pp2 = pp2;
        t.exp_pc = epc;   t.exp_flags = efl;  t.exp_halted = eh;
        vecs.push_back(t);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: queue empty, got %h expected entry", pc);
        end else begin
            e = sb.pop_front();
            compare("pc", e.idx, pc, e.pc);
            compare("flags", e.idx, {13'd0, flags}, {13'd0, e.flags});
            compare("halted", e.idx, {15'd0, halted}, {15'd0, e.halted});
        end
    endtask

    task automatic applyStimulus(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        rst_n      = t.rst_n;
        stall      = t.stall;
        instr      = t.instr;
        branch     = t.branch;
        branch_reg = t.branch_reg;
        pcs        = t.pcs;
        halt_in    = t.halt_in;
        rs_data    = t.rs_data;
        alu_z      = t.z;
        alu_n      = t.n;
        alu_v      = t.v;
        #1;
        if (t.chk_comb) begin
            compare("branch_taken", idx, {15'd0, branch_taken}, {15'd0, t.exp_bt});
            compare("pc_plus2", idx, pc_plus2, t.exp_pp2);
        end
        e.pc = t.exp_pc;
        e.flags = t.exp_flags;
        e.halted = t.exp_halted;
        e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; instr = '0; branch = 1'b0; branch_reg = 1'b0;
        pcs = 1'b0; halt_in = 1'b0; rs_data = '0; alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0;

        // Reset and first fetches
        //   r  st op     ccc   imm      br brr p h rs        z n v chk bt pp2       pc        fl    h
        addv(0, 0, OP_LLB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 0);
        addv(0, 0, OP_LLB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0002, 16'h0000, 3'b000, 0);
        addv(1, 0, OP_LLB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0002, 16'h0002, 3'b000, 0);
        addv(1, 0, OP_LLB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0004, 16'h0004, 3'b000, 0);
        // Flags from ADD, B EQ taken, B NE not taken
        addv(1, 0, OP_BR,  CC_UNC, 9'h000, 1, 1, 0, 0, 16'h0010, 0, 0, 0, 1, 1, 16'h0006, 16'h0010, 3'b000, 0);
        addv(1, 0, OP_ADD, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0012, 16'h0012, 3'b100, 0);
        addv(1, 0, OP_B,   CC_EQ,  9'h004, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h0014, 16'h001C, 3'b100, 0);
        addv(1, 0, OP_BR,  CC_UNC, 9'h000, 1, 1, 0, 0, 16'h0012, 0, 0, 0, 1, 1, 16'h001E, 16'h0012, 3'b100, 0);
        addv(1, 0, OP_B,   CC_NE,  9'h004, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0014, 16'h0014, 3'b100, 0);
        // SUB sets 011, XOR rewrites only Z, then LT and BR to 0x1234
        addv(1, 0, OP_SUB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 16'h0016, 16'h0016, 3'b011, 0);
        addv(1, 0, OP_XOR, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0018, 16'h0018, 3'b111, 0);
        addv(1, 0, OP_B,   CC_LT,  9'h002, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h001A, 16'h001E, 3'b111, 0);
        addv(1, 0, OP_BR,  CC_UNC, 9'h000, 1, 1, 0, 0, 16'h1234, 0, 0, 0, 1, 1, 16'h0020, 16'h1234, 3'b111, 0);
        // PCS at 0x0020, then stalls
        addv(1, 0, OP_BR,  CC_UNC, 9'h000, 1, 1, 0, 0, 16'h0020, 0, 0, 0, 1, 1, 16'h1236, 16'h0020, 3'b111, 0);
        addv(1, 0, OP_PCS, 3'd0, 9'h000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0022, 16'h0022, 3'b111, 0);
        for (int i = 0; i < 3; i++)
            addv(1, 1, OP_ADD, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0024, 16'h0022, 3'b111, 0);
        addv(1, 1, OP_B,   CC_UNC, 9'h050, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h0024, 16'h0022, 3'b111, 0);
        // ADD sets V only, RED leaves flags, LE not taken, GT taken onto 0x0030
        addv(1, 0, OP_ADD, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0024, 16'h0024, 3'b001, 0);
        addv(1, 0, OP_RED, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 16'h0026, 16'h0026, 3'b001, 0);
        addv(1, 0, OP_B,   CC_LE,  9'h010, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0028, 16'h0028, 3'b001, 0);
        addv(1, 0, OP_B,   CC_GT,  9'h003, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h002A, 16'h0030, 3'b001, 0);
        // HLT and 20 frozen cycles with branch strobes, stalls and flag-writing opcodes
        addv(1, 0, OP_HLT, 3'd0, 9'h000, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'h0032, 16'h0030, 3'b001, 1);
        for (int i = 0; i < 20; i++)
            addv(1, i[1], OP_ADD, CC_UNC, 9'h010, 1, i[0], i[2], (i == 5), 16'hBEEF, 1, 1, 1,
                 1, 0, 16'h0032, 16'h0030, 3'b001, 1);
        // Reset out of HALTED, then wrap-around and negative offsets
        addv(0, 0, OP_ADD, CC_UNC, 9'h010, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0032, 16'h0000, 3'b000, 0);
        addv(1, 0, OP_BR,  CC_UNC, 9'h000, 1, 1, 0, 0, 16'hFFFE, 0, 0, 0, 1, 1, 16'h0002, 16'hFFFE, 3'b000, 0);
        addv(1, 0, OP_SLL, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 3'b100, 0);
        addv(1, 0, OP_B,   CC_UNC, 9'h1FF, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h0002, 16'h0000, 3'b100, 0);
        addv(1, 0, OP_B,   CC_EQ,  9'h100, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h0002, 16'hFE02, 3'b100, 0);
        addv(1, 0, OP_PADDSB, 3'd0, 9'h000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 16'hFE04, 16'hFE04, 3'b100, 0);
        addv(1, 0, OP_B,   CC_OV,  9'h004, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'hFE06, 16'hFE06, 3'b100, 0);
        addv(1, 0, OP_B,   CC_GE,  9'h001, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'hFE08, 16'hFE0A, 3'b100, 0);
        addv(1, 0, OP_LW,  CC_UNC, 9'h004, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'hFE0C, 16'hFE0C, 3'b100, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
